// File: rtl/maxnet_pkg.sv
// maxnet_pkg
//   Shared constants for the MAXNET winner-take-all datapath.
//   N         : number of competing neurons (lanes)
//   W         : activation width in bits
//   EPS_SHIFT : inhibition weight is 2^-EPS_SHIFT
//   ITER_MAX  : iteration limit, reported as a timeout
//   ITER_W    : width of the iteration counter
package maxnet_pkg;

  localparam int N         = 4;
  localparam int W         = 8;
  localparam int EPS_SHIFT = 3;
  localparam int ITER_MAX  = 255;
  localparam int ITER_W    = 8;

endpackage

// File: rtl/maxnet_neuron.sv
// maxnet_neuron
//   One activation lane: a <= max(0, a - ((S - a) >> EPS_SHIFT)).
//   Ports:
//     clk, rst  : clock, synchronous active-high reset
//     load      : write the lane register this cycle
//     load_init : 1 = take the external value x, 0 = take the lateral update
//     x         : external initial activation
//     sum       : S = sum of all lane activations (W+2 bits, never overflows)
//     a         : registered activation
module maxnet_neuron
  import maxnet_pkg::*;
#(
  parameter int W         = maxnet_pkg::W,
  parameter int EPS_SHIFT = maxnet_pkg::EPS_SHIFT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           load_init,
  input  logic [W-1:0]   x,
  input  logic [W+1:0]   sum,
  output logic [W-1:0]   a
);

  localparam int SUM_W  = W + 2;
  localparam int DIFF_W = W + 3;

  logic [W-1:0]             a_reg;
  logic [W-1:0]             a_next;
  logic [SUM_W-1:0]         inhib;
  logic signed [DIFF_W-1:0] upd;

  // S includes this lane, so S - a is the total of the other lanes and is
  // never negative; only the final subtraction needs a sign bit.
  always_comb begin
    inhib  = (sum - {2'b00, a_reg}) >> EPS_SHIFT;
    upd    = $signed({3'b000, a_reg}) - $signed({1'b0, inhib});
    // A non-negative result is at most a_reg, so it always fits in W bits.
    a_next = upd[DIFF_W-1] ? '0 : upd[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg <= '0;
    end else if (load) begin
      a_reg <= load_init ? x : a_next;
    end
  end

  assign a = a_reg;

endmodule

// File: rtl/maxnet_datapath.sv
// maxnet_datapath
//   Four-lane MAXNET datapath: lanes inhibit each other until one survives.
//   Inputs : clk, rst (sync, active high), load_a (write lanes), load_sel
//            (1 = load x0..x3, 0 = lateral update), done (capture result),
//            x0..x3 (initial activations).
//   Outputs: is_finished (<=1 lane nonzero, or timeout), winner / max_val /
//            winner_valid (argmax, ties to lowest index), iter_cnt (updates
//            since last load, saturating), timeout (iter_cnt at limit),
//            res_winner / res_val / res_valid (result captured on done).
module maxnet_datapath
  import maxnet_pkg::*;
#(
  parameter int N         = maxnet_pkg::N,
  parameter int W         = maxnet_pkg::W,
  parameter int EPS_SHIFT = maxnet_pkg::EPS_SHIFT,
  parameter int ITER_MAX  = maxnet_pkg::ITER_MAX
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_a,
  input  logic         load_sel,
  input  logic         done,
  input  logic [W-1:0] x0,
  input  logic [W-1:0] x1,
  input  logic [W-1:0] x2,
  input  logic [W-1:0] x3,
  output logic         is_finished,
  output logic [1:0]   winner,
  output logic         winner_valid,
  output logic [W-1:0] max_val,
  output logic [7:0]   iter_cnt,
  output logic         timeout,
  output logic [1:0]   res_winner,
  output logic [W-1:0] res_val,
  output logic         res_valid
);

  localparam int SUM_W = W + 2;
  localparam int NZ_W  = $clog2(N + 1);
  localparam logic [ITER_W-1:0] ITER_LIM = ITER_W'(ITER_MAX);

  logic [W-1:0]      x_arr [N];
  logic [W-1:0]      a_arr [N];
  logic [SUM_W-1:0]  sum;
  logic [NZ_W-1:0]   nz_cnt;
  logic [1:0]        win_idx;
  logic [W-1:0]      best;
  logic              load_init;

  logic [ITER_W-1:0] iter_cnt_reg;
  logic [1:0]        res_winner_reg;
  logic [W-1:0]      res_val_reg;
  logic              res_valid_reg;

  assign x_arr[0] = x0;
  assign x_arr[1] = x1;
  assign x_arr[2] = x2;
  assign x_arr[3] = x3;

  assign load_init = load_a && load_sel;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      maxnet_neuron #(
        .W         (W),
        .EPS_SHIFT (EPS_SHIFT)
      ) u_neuron (
        .clk       (clk),
        .rst       (rst),
        .load      (load_a),
        .load_init (load_sel),
        .x         (x_arr[gi]),
        .sum       (sum),
        .a         (a_arr[gi])
      );
    end
  endgenerate

  // Sum, nonzero count and argmax all come straight off the lane registers,
  // so is_finished is valid in the cycle right after a write-back.
  always_comb begin
    sum     = '0;
    nz_cnt  = '0;
    win_idx = '0;
    best    = a_arr[0];
    for (int i = 0; i < N; i++) begin
      sum = sum + {2'b00, a_arr[i]};
      if (a_arr[i] != '0) nz_cnt = nz_cnt + 1'b1;
    end
    // Strict compare keeps the lowest index on ties.
    for (int i = 1; i < N; i++) begin
      if (a_arr[i] > best) begin
        best    = a_arr[i];
        win_idx = 2'(i);
      end
    end
  end

  // Outputs are forced to their idle values while reset is held, before the
  // registers have had an edge to clear.
  assign timeout      = !rst && (iter_cnt_reg == ITER_LIM);
  assign is_finished  = rst || (nz_cnt <= NZ_W'(1)) || (iter_cnt_reg == ITER_LIM);
  assign winner       = rst ? 2'd0 : win_idx;
  assign max_val      = rst ? '0 : best;
  assign winner_valid = !rst && (best != '0);
  assign iter_cnt     = iter_cnt_reg;
  assign res_winner   = res_winner_reg;
  assign res_val      = res_val_reg;
  assign res_valid    = res_valid_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      iter_cnt_reg   <= '0;
      res_winner_reg <= '0;
      res_val_reg    <= '0;
      res_valid_reg  <= 1'b0;
    end else begin
      if (load_init) begin
        iter_cnt_reg <= '0;
      end else if (load_a && (iter_cnt_reg != ITER_LIM)) begin
        iter_cnt_reg <= iter_cnt_reg + 1'b1;
      end

      // A fresh load invalidates any old result and wins over done.
      if (load_init) begin
        res_valid_reg <= 1'b0;
      end else if (done) begin
        res_winner_reg <= win_idx;
        res_val_reg    <= best;
        res_valid_reg  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_maxnet_datapath.sv
module tb_maxnet_datapath;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_a, load_sel, done;
  logic [7:0] x0, x1, x2, x3;
  logic       is_finished, winner_valid, timeout, res_valid;
  logic [1:0] winner, res_winner;
  logic [7:0] max_val, iter_cnt, res_val;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  maxnet_datapath dut (
    .clk          (clk),
    .rst          (rst),
    .load_a       (load_a),
    .load_sel     (load_sel),
    .done         (done),
    .x0           (x0),
    .x1           (x1),
    .x2           (x2),
    .x3           (x3),
    .is_finished  (is_finished),
    .winner       (winner),
    .winner_valid (winner_valid),
    .max_val      (max_val),
    .iter_cnt     (iter_cnt),
    .timeout      (timeout),
    .res_winner   (res_winner),
    .res_val      (res_val),
    .res_valid    (res_valid)
  );

  typedef struct {
    string      name;
    logic       la, ls, dn;
    logic [7:0] v0, v1, v2, v3;
    logic       e_fin;
    logic [1:0] e_win;
    logic       e_wv;
    logic [7:0] e_max;
    logic [7:0] e_iter;
    logic       e_to;
    logic       e_rv;
    logic [1:0] e_rwin;
    logic [7:0] e_rval;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic la, input logic ls, input logic dn,
                       input logic [7:0] v0, input logic [7:0] v1,
                       input logic [7:0] v2, input logic [7:0] v3);
    load_a = la; load_sel = ls; done = dn;
    x0 = v0; x1 = v1; x2 = v2; x3 = v3;
  endtask

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_core(input string tag, input logic fin, input logic [1:0] win,
                            input logic wv, input logic [7:0] mx,
                            input logic [7:0] it, input logic to);
    chk({tag, ".is_finished"}, int'(is_finished), int'(fin));
    chk({tag, ".winner"}, int'(winner), int'(win));
    chk({tag, ".winner_valid"}, int'(winner_valid), int'(wv));
    chk({tag, ".max_val"}, int'(max_val), int'(mx));
    chk({tag, ".iter_cnt"}, int'(iter_cnt), int'(it));
    chk({tag, ".timeout"}, int'(timeout), int'(to));
  endtask

  function automatic vec_t mk(string nm, logic la, logic ls, logic dn,
                              logic [7:0] v0, logic [7:0] v1, logic [7:0] v2, logic [7:0] v3,
                              logic fin, logic [1:0] win, logic wv, logic [7:0] mx,
                              logic [7:0] it, logic to, logic rv, logic [1:0] rwin,
                              logic [7:0] rval);
    vec_t v;
    v.name = nm; v.la = la; v.ls = ls; v.dn = dn;
    v.v0 = v0; v.v1 = v1; v.v2 = v2; v.v3 = v3;
    v.e_fin = fin; v.e_win = win; v.e_wv = wv; v.e_max = mx;
    v.e_iter = it; v.e_to = to; v.e_rv = rv; v.e_rwin = rwin; v.e_rval = rval;
    return v;
  endfunction

  initial begin
    bit first_bad_seen;
    int first_bad;

    // Hand-computed vectors; x is driven with junk during updates to show
    // it is ignored when load_sel=0.
    //            name            la ls dn  x0  x1  x2  x3  fin w wv max  it to rv rw rval
    vecs[0]  = mk("load80",       1, 1, 0,  80, 40, 20, 10, 0, 0, 1, 80, 0, 0, 0, 0, 0);
    vecs[1]  = mk("upd1",         1, 0, 0, 255,255,255,255, 0, 0, 1, 72, 1, 0, 0, 0, 0);
    vecs[2]  = mk("upd2",         1, 0, 0,   7,  3,200, 99, 0, 0, 1, 69, 2, 0, 0, 0, 0);
    vecs[3]  = mk("upd3",         1, 0, 0, 255,  0,  0,255, 0, 0, 1, 67, 3, 0, 0, 0, 0);
    vecs[4]  = mk("upd4",         1, 0, 0,   1,  2,  3,  4, 0, 0, 1, 66, 4, 0, 0, 0, 0);
    vecs[5]  = mk("upd5",         1, 0, 0, 255,255,255,255, 1, 0, 1, 66, 5, 0, 0, 0, 0);
    vecs[6]  = mk("done66",       0, 0, 1,   0,  0,  0,  0, 1, 0, 1, 66, 5, 0, 1, 0, 66);
    vecs[7]  = mk("load90",       1, 1, 0,   0,  0,  0, 90, 1, 3, 1, 90, 0, 0, 0, 0, 66);
    vecs[8]  = mk("upd90",        1, 0, 0, 200,200,200,  0, 1, 3, 1, 90, 1, 0, 0, 0, 66);
    vecs[9]  = mk("done90",       0, 0, 1,   0,  0,  0,  0, 1, 3, 1, 90, 1, 0, 1, 3, 90);
    vecs[10] = mk("load_zero",    1, 1, 0,   0,  0,  0,  0, 1, 0, 0,  0, 0, 0, 0, 3, 90);
    vecs[11] = mk("done_zero",    0, 0, 1,   0,  0,  0,  0, 1, 0, 0,  0, 0, 0, 1, 0, 0);
    vecs[12] = mk("load_and_done",1, 1, 1,   5,  9,  9,  1, 0, 1, 1,  9, 0, 0, 0, 0, 0);
    vecs[13] = mk("hold",         0, 1, 0, 100,100,100,100, 0, 1, 1,  9, 0, 0, 0, 0, 0);

    // Reset, with load and done asserted to show reset overrides them.
    rst = 1'b1;
    drive(1, 1, 1, 8'd11, 8'd22, 8'd33, 8'd44);
    step();
    step();
    check_core("reset", 1, 0, 0, 0, 0, 0);
    chk("reset.res_valid", int'(res_valid), 0);
    chk("reset.res_val", int'(res_val), 0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    step();

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].la, vecs[i].ls, vecs[i].dn, vecs[i].v0, vecs[i].v1, vecs[i].v2, vecs[i].v3);
      step();
      check_core(vecs[i].name, vecs[i].e_fin, vecs[i].e_win, vecs[i].e_wv,
                 vecs[i].e_max, vecs[i].e_iter, vecs[i].e_to);
      chk({vecs[i].name, ".res_valid"}, int'(res_valid), int'(vecs[i].e_rv));
      chk({vecs[i].name, ".res_winner"}, int'(res_winner), int'(vecs[i].e_rwin));
      chk({vecs[i].name, ".res_val"}, int'(res_val), int'(vecs[i].e_rval));
      $display("vec %0d %s: fin=%0d win=%0d max=%0d iter=%0d rv=%0d rval=%0d",
               i, vecs[i].name, is_finished, winner, max_val, iter_cnt, res_valid, res_val);
    end

    // Tie that never resolves: settles at {7,7,0,0} and ends by timeout.
    drive(1, 1, 0, 8'd50, 8'd50, 8'd0, 8'd0);
    step();
    drive(1, 0, 0, 8'd0, 8'd0, 8'd0, 8'd0);
    first_bad_seen = 1'b0;
    first_bad = 0;
    for (int k = 1; k <= 254; k++) begin
      step();
      if ((is_finished || timeout) && !first_bad_seen) begin
        first_bad_seen = 1'b1;
        first_bad = k;
      end
      if (k == 18) chk("tie.settle_max", int'(max_val), 7);
    end
    chk("tie.early_finish_iter", first_bad, 0);
    step();
    check_core("tie.timeout", 1, 0, 1, 7, 255, 1);
    step();
    chk("tie.iter_saturate", int'(iter_cnt), 255);
    chk("tie.max_hold", int'(max_val), 7);
    $display("tie: iter=%0d timeout=%0d fin=%0d max=%0d", iter_cnt, timeout, is_finished, max_val);

    // Capture a result, then reset mid-iteration and restart.
    drive(0, 0, 1, 0, 0, 0, 0);
    step();
    drive(1, 1, 0, 8'd80, 8'd40, 8'd20, 8'd10);
    step();
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) step();
    chk("midrst.pre_max", int'(max_val), 67);
    rst = 1'b1;
    drive(1, 0, 1, 0, 0, 0, 0);
    step();
    check_core("midrst", 1, 0, 0, 0, 0, 0);
    chk("midrst.res_valid", int'(res_valid), 0);
    chk("midrst.res_val", int'(res_val), 0);
    rst = 1'b0;
    drive(1, 1, 0, 8'd80, 8'd40, 8'd20, 8'd10);
    step();
    check_core("restart.load", 0, 0, 1, 80, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    step();
    check_core("restart.upd1", 0, 0, 1, 72, 1, 0);
    $display("restart: iter=%0d max=%0d", iter_cnt, max_val);

    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
